// File: rtl/vec_pkg.sv
// vec_pkg: opcodes, sequencer state encoding and instruction field offsets.
// Field offsets are relative to ADDR_W: instr = {op, ra, rb, addr}.
package vec_pkg;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;
  localparam int RB_OFS = 0;
  localparam int RA_OFS = 2;
  localparam int OP_OFS = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_WB, S_ST_REQ, S_EX_RD, S_EX_WAIT, S_EX_WB
  } state_t;
endpackage

// File: rtl/vec_rf_sequencer.sv
// vec_rf_sequencer: issue controller sequencing LOAD/STORE/ALU ops onto a 4x512b vector RF.
// Ports: clk, rst_n (async active-low); instr_valid/instr/instr_ready handshake;
//   RF strobes rf_re/rf_raddr1/rf_raddr2/rf_we/rf_dw/rf_waddr/wdata_sel;
//   ALU alu_start/alu_op/alu_done; memory mem_req/mem_we/mem_addr/mem_ack;
//   status done (pulse), err (sticky ALU timeout), retired (wrapping count).
module vec_rf_sequencer
  import vec_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int INSTR_W     = 6 + ADDR_W,
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               rf_re,
  output logic [1:0]         rf_raddr1,
  output logic [1:0]         rf_raddr2,
  output logic               rf_we,
  output logic               rf_dw,
  output logic [1:0]         rf_waddr,
  output logic               wdata_sel,
  output logic               alu_start,
  output logic               alu_op,
  input  logic               alu_done,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   retired
);
  localparam int TMR_W = $clog2(ALU_TIMEOUT);
  state_t r_state, w_next;
  logic [1:0] r_op, r_ra, r_rb, w_op, w_ra, w_rb;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [TMR_W-1:0] r_timer;
  logic w_accept, w_timeout, w_retire, w_ex, w_rd;
  // Outputs are registered from the next-state decode, so field values must be
  // the freshly accepted ones on the accept edge.
  always_comb begin
    w_accept  = instr_valid && r_state == S_IDLE;
    w_op      = w_accept ? instr[ADDR_W+OP_OFS +: 2] : r_op;
    w_ra      = w_accept ? instr[ADDR_W+RA_OFS +: 2] : r_ra;
    w_rb      = w_accept ? instr[ADDR_W+RB_OFS +: 2] : r_rb;
    w_addr    = w_accept ? instr[ADDR_W-1:0] : r_addr;
    w_timeout = r_state == S_EX_WAIT && !alu_done && r_timer == TMR_W'(ALU_TIMEOUT - 1);
    w_next    = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_op == OP_LOAD ? S_LD_REQ : w_op == OP_STORE ? S_ST_REQ : S_EX_RD;
      S_LD_REQ:  if (mem_ack) w_next = S_LD_WB;
      S_LD_WB:   w_next = S_IDLE;
      S_ST_REQ:  if (mem_ack) w_next = S_IDLE;
      S_EX_RD:   w_next = S_EX_WAIT;
      S_EX_WAIT: w_next = alu_done ? S_EX_WB : w_timeout ? S_IDLE : S_EX_WAIT;
      default:   w_next = S_IDLE;
    endcase
    w_retire = w_next == S_IDLE && r_state != S_IDLE;
    w_ex     = w_next == S_EX_RD || w_next == S_EX_WAIT || w_next == S_EX_WB;
    w_rd     = w_ex || w_next == S_ST_REQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_addr      <= '0;
      r_timer     <= '0;
      instr_ready <= 1'b1;
      rf_re       <= 1'b0;
      rf_raddr1   <= '0;
      rf_raddr2   <= '0;
      rf_we       <= 1'b0;
      rf_dw       <= 1'b0;
      rf_waddr    <= '0;
      wdata_sel   <= 1'b0;
      alu_start   <= 1'b0;
      alu_op      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      retired     <= '0;
    end else begin
      r_state     <= w_next;
      r_op        <= w_op;
      r_ra        <= w_ra;
      r_rb        <= w_rb;
      r_addr      <= w_addr;
      r_timer     <= r_state == S_EX_WAIT ? r_timer + 1'b1 : '0;
      instr_ready <= w_next == S_IDLE;
      rf_re       <= w_rd;
      rf_raddr1   <= w_rd ? w_ra : '0;
      rf_raddr2   <= w_ex ? w_rb : '0;
      rf_we       <= w_next == S_LD_WB;
      rf_dw       <= w_next == S_EX_WB;
      rf_waddr    <= w_next == S_LD_WB ? w_ra : '0;
      wdata_sel   <= w_next == S_EX_WB;
      alu_start   <= w_next == S_EX_RD;
      alu_op      <= w_ex && w_op == OP_MUL;
      mem_req     <= w_next == S_LD_REQ || w_next == S_ST_REQ;
      mem_we      <= w_next == S_ST_REQ;
      mem_addr    <= w_addr;
      done        <= w_retire;
      err         <= err | w_timeout;
      retired     <= retired + CNT_W'(w_retire);
    end
  end
endmodule

// File: tb/tb_vec_rf_sequencer.sv
// tb_vec_rf_sequencer: directed self-checking bench for vec_rf_sequencer.
module tb_vec_rf_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, alu_done = 1'b0, mem_ack = 1'b0;
  logic [14:0] instr = '0;
  logic instr_ready, rf_re, rf_we, rf_dw, wdata_sel, alu_start, alu_op, mem_req, mem_we, done, err;
  logic [1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [8:0] mem_addr;
  logic [15:0] retired;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  vec_rf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_re(rf_re), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we), .rf_dw(rf_dw),
    .rf_waddr(rf_waddr), .wdata_sel(wdata_sel), .alu_start(alu_start), .alu_op(alu_op),
    .alu_done(alu_done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .done(done), .err(err), .retired(retired)
  );

  task automatic test_reset;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", instr_ready); end
    checks++; if ({rf_re, rf_we, rf_dw, alu_start, mem_req, mem_we, done, err} !== 8'h00) begin errors++; $display("FAIL rst_strobes got %0h exp 0", {rf_re, rf_we, rf_dw, alu_start, mem_req, mem_we, done, err}); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rst_retired got %0d exp 0", retired); end
    rst_n = 1'b1;
  endtask

  task automatic test_load;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'b00, 2'd1, 2'd0, 9'h005};
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({mem_req, mem_we, instr_ready} !== 3'b100) begin errors++; $display("FAIL ld_req1 req/we/ready got %b exp 100", {mem_req, mem_we, instr_ready}); end
    checks++; if (mem_addr !== 9'h005) begin errors++; $display("FAIL ld_addr got %0h exp 5", mem_addr); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL ld_req2 req/we got %b%b exp 10", mem_req, rf_we); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if ({mem_req, rf_we, rf_dw, wdata_sel} !== 4'b0100) begin errors++; $display("FAIL ld_wb req/we/dw/sel got %b exp 0100", {mem_req, rf_we, rf_dw, wdata_sel}); end
    checks++; if (rf_waddr !== 2'd1) begin errors++; $display("FAIL ld_waddr got %0d exp 1", rf_waddr); end
    @(negedge clk);
    checks++; if ({rf_we, done, instr_ready} !== 3'b011) begin errors++; $display("FAIL ld_done we/done/ready got %b exp 011", {rf_we, done, instr_ready}); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL ld_retired got %0d exp 1", retired); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ld_done_pulse got %0b exp 0", done); end
  endtask

  task automatic test_store;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'b01, 2'd3, 2'd0, 9'h1FF};
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({rf_re, mem_req, mem_we} !== 3'b111) begin errors++; $display("FAIL st_req re/req/we got %b exp 111", {rf_re, mem_req, mem_we}); end
    checks++; if (rf_raddr1 !== 2'd3 || mem_addr !== 9'h1FF) begin errors++; $display("FAIL st_addr raddr1=%0d mem_addr=%0h exp 3 1ff", rf_raddr1, mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if ({rf_re, mem_req, mem_we, rf_we, done} !== 5'b00001) begin errors++; $display("FAIL st_done re/req/we/rfwe/done got %b exp 00001", {rf_re, mem_req, mem_we, rf_we, done}); end
    checks++; if (retired !== 16'd2) begin errors++; $display("FAIL st_retired got %0d exp 2", retired); end
  endtask

  task automatic test_mul;
    int starts = 0, dws = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'b11, 2'd0, 2'd1, 9'h000};
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({alu_start, rf_re, alu_op} !== 3'b111) begin errors++; $display("FAIL mul_rd start/re/op got %b exp 111", {alu_start, rf_re, alu_op}); end
    checks++; if (rf_raddr1 !== 2'd0 || rf_raddr2 !== 2'd1) begin errors++; $display("FAIL mul_raddr got %0d %0d exp 0 1", rf_raddr1, rf_raddr2); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      starts += int'(alu_start); dws += int'(rf_dw);
      if (i == 4) alu_done = 1'b1;
    end
    checks++; if (starts != 0 || dws != 0 || rf_re !== 1'b1) begin errors++; $display("FAIL mul_wait starts=%0d dws=%0d re=%0b exp 0 0 1", starts, dws, rf_re); end
    @(negedge clk);
    alu_done = 1'b0;
    checks++; if ({rf_dw, rf_we, wdata_sel, alu_op, rf_re} !== 5'b10111) begin errors++; $display("FAIL mul_wb dw/we/sel/op/re got %b exp 10111", {rf_dw, rf_we, wdata_sel, alu_op, rf_re}); end
    @(negedge clk);
    checks++; if ({rf_dw, done, err, alu_op} !== 4'b0100) begin errors++; $display("FAIL mul_done dw/done/err/op got %b exp 0100", {rf_dw, done, err, alu_op}); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL mul_retired got %0d exp 3", retired); end
  endtask

  task automatic test_timeout;
    int n = 0, dws = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'b10, 2'd2, 2'd3, 9'h000};
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({alu_start, alu_op, err} !== 3'b100) begin errors++; $display("FAIL to_rd start/op/err got %b exp 100", {alu_start, alu_op, err}); end
    for (int i = 0; i < 100 && !instr_ready; i++) begin
      @(negedge clk);
      dws += int'(rf_dw);
      if (!instr_ready) begin
        n++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_early_err cycle %0d got 1 exp 0", n); end
      end
    end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL to_bound ready got %0b exp 1", instr_ready); end
    checks++; if (n != 64) begin errors++; $display("FAIL to_cycles got %0d exp 64", n); end
    checks++; if ({done, err, rf_dw} !== 3'b110 || dws != 0) begin errors++; $display("FAIL to_abort done/err/dw got %b dws=%0d exp 110 0", {done, err, rf_dw}, dws); end
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL to_retired got %0d exp 4", retired); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", err); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (err !== 1'b0 || retired !== 16'd0) begin errors++; $display("FAIL b2b_rst err=%0b retired=%0d exp 0 0", err, retired); end
    instr_valid = 1'b1; instr = {2'b00, 2'd2, 2'd0, 9'h010};
    @(negedge clk);
    instr = {2'b10, 2'd0, 2'd1, 9'h000};
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 2'd2) begin errors++; $display("FAIL b2b_ldwb we=%0b waddr=%0d exp 1 2", rf_we, rf_waddr); end
    @(negedge clk);
    checks++; if ({done, instr_ready} !== 2'b11 || retired !== 16'd1) begin errors++; $display("FAIL b2b_done done/ready=%b retired=%0d exp 11 1", {done, instr_ready}, retired); end
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({alu_start, alu_op, instr_ready} !== 3'b100 || rf_raddr2 !== 2'd1) begin errors++; $display("FAIL b2b_accept start/op/ready=%b raddr2=%0d exp 100 1", {alu_start, alu_op, instr_ready}, rf_raddr2); end
    alu_done = 1'b1;
    @(negedge clk);
    checks++; if (rf_re !== 1'b1 || rf_dw !== 1'b0) begin errors++; $display("FAIL b2b_wait re=%0b dw=%0b exp 1 0", rf_re, rf_dw); end
    @(negedge clk);
    alu_done = 1'b0;
    checks++; if (rf_dw !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL b2b_wb dw=%0b we=%0b exp 1 0", rf_dw, rf_we); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || retired !== 16'd2) begin errors++; $display("FAIL b2b_retired done=%0b retired=%0d exp 1 2", done, retired); end
  endtask

  task automatic test_reset_mid;
    int wes = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'b00, 2'd1, 2'd0, 9'h0AA};
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req got %0b exp 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, instr_ready, rf_we} !== 3'b010 || retired !== 16'd0) begin errors++; $display("FAIL rm_async req/ready/we=%b retired=%0d exp 010 0", {mem_req, instr_ready, rf_we}, retired); end
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wes += int'(rf_we) + int'(mem_req) + int'(done);
    end
    mem_ack = 1'b0;
    checks++; if (wes != 0 || instr_ready !== 1'b1 || retired !== 16'd0) begin errors++; $display("FAIL rm_after strobes=%0d ready=%0b retired=%0d exp 0 1 0", wes, instr_ready, retired); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_mul();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
